// File: rtl/tagger_pkg.sv
// Shared constants for the pulse-tagging datapath: FSM encoding, default
// widths and the tagger record width used by the FIFO and the tagger.
package tagger_pkg;

  localparam int RUNLEN_W_DEF = 48;
  localparam int CNT_W_DEF    = 32;
  localparam int REC_W        = 47;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
  localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // next count: clear, saturating increment or hold
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != ALL_ONES)) begin
      count_d = count_q + ONE;
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/tagger_run_ctrl.sv
// Run sequencer for the pulse tagger: drives the tagger controls from host
// commands, enforces run length and keeps record/loss statistics.
module tagger_run_ctrl
  import tagger_pkg::*;
#(
  parameter int RUNLEN_W = RUNLEN_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_start,
  input  logic                cmd_stop,
  input  logic                cmd_clear,
  input  logic [RUNLEN_W-1:0] run_length,
  input  logic                stop_on_overflow,
  input  logic                tagger_ready,
  input  logic                fifo_full,
  output logic                fifo_wr,
  output logic                reset_counter,
  output logic                counter_operate,
  output logic                capture_operate,
  output logic                running,
  output logic                run_done,
  output logic                overflow,
  output logic [CNT_W-1:0]    record_count,
  output logic [CNT_W-1:0]    lost_count
);

  localparam logic [RUNLEN_W-1:0] RL_ONE = {{(RUNLEN_W-1){1'b0}}, 1'b1};

  logic [2:0]          state_d, state_q;
  logic [RUNLEN_W-1:0] run_len_d, run_len_q;
  logic [RUNLEN_W-1:0] elapsed_d, elapsed_q;
  logic                reset_counter_d, reset_counter_q;
  logic                operate_d, operate_q;
  logic                running_d, running_q;
  logic                run_done_d, run_done_q;
  logic                overflow_d, overflow_q;
  logic                rec_evt_s, lost_evt_s, len_hit_s, stats_clr_s;

  assign rec_evt_s   = tagger_ready & ~fifo_full;
  assign lost_evt_s  = tagger_ready & fifo_full;
  assign stats_clr_s = (state_q == ST_CLEAR);
  assign len_hit_s   = (run_len_q != '0) && (elapsed_q == (run_len_q - RL_ONE));

  // FSM, run-length bookkeeping and next values of the registered outputs
  always_comb begin
    state_d   = state_q;
    run_len_d = run_len_q;
    elapsed_d = elapsed_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_clear) begin
          state_d = ST_CLEAR;
        end else if (cmd_start) begin
          state_d   = ST_START;
          run_len_d = run_length;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        state_d   = ST_IDLE;
        elapsed_d = '0;
      end
      ST_START: begin
        state_d   = ST_RUN;
        elapsed_d = '0;
      end
      ST_RUN: begin
        elapsed_d = elapsed_q + RL_ONE;
        if (cmd_stop || len_hit_s || (stop_on_overflow && lost_evt_s)) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_STOP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // controls are decoded from the next state so they line up with it
    reset_counter_d = (state_d == ST_CLEAR) || (state_d == ST_START);
    operate_d       = (state_d == ST_RUN);
    running_d       = (state_d == ST_START) || (state_d == ST_RUN) || (state_d == ST_STOP);
    run_done_d      = (state_q == ST_STOP);

    if (stats_clr_s) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q | lost_evt_s;
    end
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      run_len_q       <= '0;
      elapsed_q       <= '0;
      reset_counter_q <= 1'b0;
      operate_q       <= 1'b0;
      running_q       <= 1'b0;
      run_done_q      <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      run_len_q       <= run_len_d;
      elapsed_q       <= elapsed_d;
      reset_counter_q <= reset_counter_d;
      operate_q       <= operate_d;
      running_q       <= running_d;
      run_done_q      <= run_done_d;
      overflow_q      <= overflow_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_record_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (stats_clr_s),
    .inc   (rec_evt_s),
    .count (record_count)
  );

  sat_counter #(.W(CNT_W)) u_lost_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (stats_clr_s),
    .inc   (lost_evt_s),
    .count (lost_count)
  );

  assign fifo_wr         = rec_evt_s;
  assign reset_counter   = reset_counter_q;
  assign counter_operate = operate_q;
  assign capture_operate = operate_q;
  assign running         = running_q;
  assign run_done        = run_done_q;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_tagger_run_ctrl.sv
// Self-checking bench for tagger_run_ctrl: directed run scenarios with
// randomized record traffic checked against a counting reference model.
module tb_tagger_run_ctrl;

  localparam int RW   = 16;
  localparam int CW   = 10;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_start = 1'b0, cmd_stop = 1'b0, cmd_clear = 1'b0;
  logic [RW-1:0] run_length = '0;
  logic          stop_on_overflow = 1'b0;
  logic          tagger_ready = 1'b0, fifo_full = 1'b0;
  logic          fifo_wr, reset_counter, counter_operate, capture_operate;
  logic          running, run_done, overflow;
  logic [CW-1:0] record_count, lost_count;

  int tests = 0;
  int fails = 0;
  int exp_rec = 0, exp_lost = 0;
  bit exp_ovf = 1'b0;
  int cyc = 0, start_cyc = 0, done_cyc = 0;
  int n_op = 0, n_cap = 0, n_rc = 0, n_done = 0, n_wr = 0;
  int len;

  always #5 clk = ~clk;

  tagger_run_ctrl #(.RUNLEN_W(RW), .CNT_W(CW)) dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_start        (cmd_start),
    .cmd_stop         (cmd_stop),
    .cmd_clear        (cmd_clear),
    .run_length       (run_length),
    .stop_on_overflow (stop_on_overflow),
    .tagger_ready     (tagger_ready),
    .fifo_full        (fifo_full),
    .fifo_wr          (fifo_wr),
    .reset_counter    (reset_counter),
    .counter_operate  (counter_operate),
    .capture_operate  (capture_operate),
    .running          (running),
    .run_done         (run_done),
    .overflow         (overflow),
    .record_count     (record_count),
    .lost_count       (lost_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_obs();
    n_op = 0; n_cap = 0; n_rc = 0; n_done = 0; n_wr = 0;
  endtask

  // One clock cycle: drive record inputs, check fifo_wr, advance the model, check statistics.
  task automatic tick(input bit tr, input bit ff, input bit zero);
    tagger_ready = tr;
    fifo_full    = ff;
    #1;
    chk("fifo_wr", fifo_wr, tr & ~ff);
    if (fifo_wr) n_wr++;
    @(posedge clk);
    if (reset || zero) begin
      exp_rec = 0; exp_lost = 0; exp_ovf = 1'b0;
    end else begin
      if (tr && !ff && exp_rec < MAXC) exp_rec++;
      if (tr && ff) begin
        if (exp_lost < MAXC) exp_lost++;
        exp_ovf = 1'b1;
      end
    end
    cyc++;
    #1;
    chk("record_count", record_count, exp_rec);
    chk("lost_count", lost_count, exp_lost);
    chk("overflow", overflow, exp_ovf);
    if (counter_operate) n_op++;
    if (capture_operate) n_cap++;
    if (reset_counter) n_rc++;
    if (run_done) begin
      n_done++;
      done_cyc = cyc;
    end
    cmd_start = 1'b0;
    cmd_stop  = 1'b0;
    cmd_clear = 1'b0;
  endtask

  task automatic do_clear();
    cmd_clear = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    // reset state
    reset = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("rst_reset_counter", reset_counter, 1'b0);
    chk("rst_counter_operate", counter_operate, 1'b0);
    chk("rst_capture_operate", capture_operate, 1'b0);
    chk("rst_running", running, 1'b0);
    chk("rst_run_done", run_done, 1'b0);
    reset = 1'b0;
    tick(1'b0, 1'b0, 1'b0);

    // fixed-length run of 100 cycles, no records
    clr_obs();
    run_length = RW'(100);
    cmd_start  = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    start_cyc = cyc;
    chk("start_running", running, 1'b1);
    for (int i = 0; i < 110; i++) tick(1'b0, 1'b0, 1'b0);
    chk("len100_operate_cycles", n_op, 100);
    chk("len100_capture_cycles", n_cap, 100);
    chk("len100_reset_counter_cycles", n_rc, 1);
    chk("len100_done_count", n_done, 1);
    chk("len100_done_latency", done_cyc - start_cyc, 102);
    chk("len100_idle_running", running, 1'b0);

    // unlimited run stopped by command after 500 cycles, record in STOP cycle
    do_clear();
    clr_obs();
    run_length = '0;
    cmd_start  = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 500; i++) tick(1'b0, 1'b0, 1'b0);
    cmd_stop = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    chk("stop_ctrl_low", counter_operate, 1'b0);
    chk("stop_running", running, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    chk("cmdstop_operate_cycles", n_op, 500);
    chk("cmdstop_late_record", record_count, 1);
    chk("cmdstop_run_done", run_done, 1'b1);

    // random-length run with random record traffic
    clr_obs();
    len = $urandom_range(50, 300);
    run_length = RW'(len);
    cmd_start  = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < len + 4; i++)
      tick(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'b0);
    chk("rand_operate_cycles", n_op, len);
    chk("rand_done_count", n_done, 1);

    // 10 accepted then 3 lost records in IDLE
    do_clear();
    clr_obs();
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0);
    chk("burst_records", record_count, 10);
    chk("burst_lost", lost_count, 3);
    chk("burst_overflow", overflow, 1'b1);
    chk("burst_fifo_wr_pulses", n_wr, 10);

    // stop on first lost record at RUN cycle 20
    do_clear();
    clr_obs();
    stop_on_overflow = 1'b1;
    run_length = '0;
    cmd_start  = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 19; i++) tick(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    chk("ovf_stop_operate", counter_operate, 1'b0);
    chk("ovf_stop_lost", lost_count, 1);
    chk("ovf_operate_cycles", n_op, 20);
    tick(1'b0, 1'b0, 1'b0);
    chk("ovf_run_done", run_done, 1'b1);
    stop_on_overflow = 1'b0;

    // clear beats start; clear ignored while running
    tick(1'b1, 1'b0, 1'b0);
    cmd_clear = 1'b1;
    cmd_start = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    chk("clr_pri_reset_counter", reset_counter, 1'b1);
    chk("clr_pri_running", running, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    chk("clr_pri_no_run", running, 1'b0);
    chk("clr_pri_operate", counter_operate, 1'b0);
    chk("clr_pri_records_zero", record_count, 0);
    clr_obs();
    run_length = RW'(30);
    cmd_start  = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0);
    cmd_clear = 1'b1;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("clr_in_run_operate", counter_operate, 1'b1);
    chk("clr_in_run_records", record_count, 6);
    for (int i = 0; i < 30; i++) tick(1'b0, 1'b0, 1'b0);
    chk("clr_in_run_cycles", n_op, 30);

    // reset in the middle of a run
    clr_obs();
    run_length = '0;
    cmd_start  = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 49; i++) tick(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick(1'b1, 1'b0, 1'b0);
    chk("midrst_operate", counter_operate, 1'b0);
    chk("midrst_capture", capture_operate, 1'b0);
    chk("midrst_running", running, 1'b0);
    chk("midrst_reset_counter", reset_counter, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0);
    chk("midrst_no_done", n_done, 0);
    chk("midrst_run_cycles", n_op, 50);

    // saturation of both counters
    for (int i = 0; i < MAXC + 5; i++) tick(1'b1, 1'b0, 1'b0);
    chk("sat_records", record_count, MAXC);
    for (int i = 0; i < MAXC + 5; i++) tick(1'b1, 1'b1, 1'b0);
    chk("sat_lost", lost_count, MAXC);
    tick(1'b1, 1'b0, 1'b0);
    chk("sat_records_hold", record_count, MAXC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
